// File: rtl/mcs4_bus_sequencer.sv
// CPU-side machine-cycle sequencer for the 4-bit multiplexed MCS-4 bus.
// Steps through A1 A2 A3 M1 M2 X1 X2 X3. It drives the fetch address and the
// SRC/WRR data onto the bus. It captures OPR/OPA and RDR data from the ROM/IO chips.
module mcs4_bus_sequencer #(
  parameter logic [3:0] OP_SRC = 4'h2,
  parameter logic [3:0] OP_IOR = 4'hE,
  parameter logic [3:0] FN_WRR = 4'h2,
  parameter logic [3:0] FN_RDR = 4'hA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [11:0] fetch_addr,
  input  logic [7:0]  src_value,
  input  logic [3:0]  wr_data,
  input  logic [3:0]  bus_in,
  output logic [3:0]  bus_out,
  output logic        bus_oe,
  output logic        sync,
  output logic        cm_rom,
  output logic [2:0]  phase,
  output logic [7:0]  instr,
  output logic        instr_valid,
  output logic [3:0]  rd_data,
  output logic        rd_valid,
  output logic        src_active
);

  typedef enum logic [2:0] {
    PH_A1 = 3'd0,
    PH_A2 = 3'd1,
    PH_A3 = 3'd2,
    PH_M1 = 3'd3,
    PH_M2 = 3'd4,
    PH_X1 = 3'd5,
    PH_X2 = 3'd6,
    PH_X3 = 3'd7
  } phase_t;

  phase_t      phase_q, phase_d;
  logic [11:0] addr_q;
  logic [3:0]  opr_q, opa_q;
  logic [7:0]  src_q;
  logic        idle_q;
  logic [7:0]  instr_q;
  logic        instr_valid_q;
  logic [3:0]  rd_data_q;
  logic        rd_valid_q;
  logic        src_active_q;
  logic        is_src, is_wrr, is_rdr;

  assign is_src = (opr_q == OP_SRC) && opa_q[0];
  assign is_wrr = (opr_q == OP_IOR) && (opa_q == FN_WRR);
  assign is_rdr = (opr_q == OP_IOR) && (opa_q == FN_RDR);

  // Phase sequencing: free-running through the cycle, parking in X3 until run is high.
  always_comb begin
    phase_d = phase_q;
    if (phase_q == PH_X3) begin
      if (run) phase_d = PH_A1;
    end else begin
      phase_d = phase_t'(phase_q + 3'd1);
    end
  end

  // Phase register plus every bus latch; each sample happens on the edge that ends its phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q       <= PH_X3;
      addr_q        <= '0;
      opr_q         <= '0;
      opa_q         <= '0;
      src_q         <= '0;
      idle_q        <= 1'b1;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      src_active_q  <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      idle_q        <= (phase_q == PH_X3) && !run;
      instr_valid_q <= (phase_q == PH_M2);
      rd_valid_q    <= (phase_q == PH_X2) && is_rdr;
      case (phase_q)
        PH_M1: opr_q <= bus_in;
        PH_M2: begin
          opa_q   <= bus_in;
          instr_q <= {opr_q, bus_in};
        end
        PH_X1: src_q <= src_value;
        PH_X2: if (is_rdr) rd_data_q <= bus_in;
        PH_X3: begin
          if (run) addr_q <= fetch_addr;
          if (!idle_q && is_src) src_active_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Bus drive and CM-ROM strobe per phase; the bus is released wherever no transfer is due.
  always_comb begin
    bus_oe  = 1'b0;
    bus_out = 4'h0;
    cm_rom  = 1'b0;
    case (phase_q)
      PH_A1: begin
        bus_oe  = 1'b1;
        bus_out = addr_q[3:0];
      end
      PH_A2: begin
        bus_oe  = 1'b1;
        bus_out = addr_q[7:4];
      end
      PH_A3: begin
        bus_oe  = 1'b1;
        bus_out = addr_q[11:8];
        cm_rom  = 1'b1;
      end
      PH_M2: cm_rom = (opr_q == OP_IOR);
      PH_X2: begin
        if (is_src) begin
          bus_oe  = 1'b1;
          bus_out = src_q[7:4];
          cm_rom  = 1'b1;
        end else if (is_wrr) begin
          bus_oe  = 1'b1;
          bus_out = wr_data;
        end
      end
      PH_X3: begin
        if (!idle_q && is_src) begin
          bus_oe  = 1'b1;
          bus_out = src_q[3:0];
        end
      end
      default: ;
    endcase
  end

  assign sync        = (phase_q == PH_X3);
  assign phase       = phase_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_valid    = rd_valid_q;
  assign src_active  = src_active_q;

endmodule

// File: tb/tb_mcs4_bus_sequencer.sv
// Bench for mcs4_bus_sequencer: directed scenarios followed by randomized machine cycles.
// Expected bus activity for every phase is derived from the instruction's meaning.
module tb_mcs4_bus_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [11:0] fetch_addr;
  logic [7:0]  src_value;
  logic [3:0]  wr_data;
  logic [3:0]  bus_in;
  logic [3:0]  bus_out;
  logic        bus_oe;
  logic        sync;
  logic        cm_rom;
  logic [2:0]  phase;
  logic [7:0]  instr;
  logic        instr_valid;
  logic [3:0]  rd_data;
  logic        rd_valid;
  logic        src_active;

  int vectors = 0;
  int miscompares = 0;

  // Reference state: what an observer of the bus should believe at each point.
  logic [11:0] cur_addr;
  logic [7:0]  exp_instr;
  logic [3:0]  exp_rd;
  logic        exp_sa;
  logic        dut_idle;

  mcs4_bus_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run), .fetch_addr(fetch_addr),
    .src_value(src_value), .wr_data(wr_data), .bus_in(bus_in),
    .bus_out(bus_out), .bus_oe(bus_oe), .sync(sync), .cm_rom(cm_rom),
    .phase(phase), .instr(instr), .instr_valid(instr_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .src_active(src_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Inputs change on the falling edge; outputs are then sampled 1 time unit later.
  task automatic applyStimulus(input logic r, input logic [11:0] fa, input logic [7:0] sv,
                               input logic [3:0] wd, input logic [3:0] bi);
    @(negedge clk);
    run        = r;
    fetch_addr = fa;
    src_value  = sv;
    wr_data    = wd;
    bus_in     = bi;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [2:0] e_ph, input logic e_oe,
                             input logic [3:0] e_out, input logic e_cm, input logic e_iv,
                             input logic e_rv);
    chk({tag, " phase"},       12'(phase),       12'(e_ph));
    chk({tag, " sync"},        12'(sync),        12'(e_ph == 3'd7));
    chk({tag, " bus_oe"},      12'(bus_oe),      12'(e_oe));
    if (e_oe) chk({tag, " bus_out"}, 12'(bus_out), 12'(e_out));
    chk({tag, " cm_rom"},      12'(cm_rom),      12'(e_cm));
    chk({tag, " instr_valid"}, 12'(instr_valid), 12'(e_iv));
    chk({tag, " instr"},       12'(instr),       12'(exp_instr));
    chk({tag, " rd_valid"},    12'(rd_valid),    12'(e_rv));
    chk({tag, " rd_data"},     12'(rd_data),     12'(exp_rd));
    chk({tag, " src_active"},  12'(src_active),  12'(exp_sa));
  endtask

  task automatic resetModel();
    exp_instr = 8'h00;
    exp_rd    = 4'h0;
    exp_sa    = 1'b0;
    dut_idle  = 1'b1;
  endtask

  // One clock parked in X3; go=1 launches the next cycle from address fa.
  task automatic idleStep(input logic go, input logic [11:0] fa);
    applyStimulus(go, fa, 8'($urandom), 4'($urandom), 4'($urandom));
    checkOutput("idle X3", 3'd7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    if (go) begin
      cur_addr = fa;
      dut_idle = 1'b0;
    end
  endtask

  // A full machine cycle fetching {opr,opa} at addr, optionally aborted by reset in phase abort_at.
  task automatic runCycle(input logic [11:0] addr, input logic [3:0] opr, input logic [3:0] opa,
                          input logic [7:0] sv, input logic [3:0] wd, input logic [3:0] rdn,
                          input logic leave, input logic [11:0] next_addr, input int abort_at);
    logic is_src, is_wrr, is_rdr;
    logic e_oe, e_cm, e_iv, e_rv, r;
    logic [3:0]  e_out, wd_in, bi;
    logic [7:0]  sv_in;
    logic [11:0] fa;
    is_src = (opr == 4'h2) && opa[0];
    is_wrr = (opr == 4'hE) && (opa == 4'h2);
    is_rdr = (opr == 4'hE) && (opa == 4'hA);
    if (dut_idle) idleStep(1'b1, addr);
    for (int p = 0; p < 8; p++) begin
      r = 1'b0; fa = 12'($urandom); sv_in = 8'($urandom);
      wd_in = 4'($urandom); bi = 4'($urandom);
      if (p == 3) bi = opr;
      if (p == 4) bi = opa;
      if (p == 5) sv_in = sv;
      if (p == 6) begin wd_in = wd; bi = rdn; end
      if (p == 7 && leave) begin r = 1'b1; fa = next_addr; end
      applyStimulus(r, fa, sv_in, wd_in, bi);
      if (p == abort_at) begin
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        resetModel();
        checkOutput("abort", 3'd7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("abort bus_out", 12'(bus_out), 12'h0);
        rst_n = 1'b1;
        break;
      end
      e_oe = 1'b0; e_out = 4'h0; e_cm = 1'b0; e_iv = 1'b0; e_rv = 1'b0;
      case (p)
        0: begin e_oe = 1'b1; e_out = cur_addr[3:0]; end
        1: begin e_oe = 1'b1; e_out = cur_addr[7:4]; end
        2: begin e_oe = 1'b1; e_out = cur_addr[11:8]; e_cm = 1'b1; end
        4: e_cm = (opr == 4'hE);
        5: e_iv = 1'b1;
        6: begin
          e_oe  = is_src || is_wrr;
          e_out = is_src ? sv[7:4] : wd;
          e_cm  = is_src;
        end
        7: begin e_oe = is_src; e_out = sv[3:0]; e_rv = is_rdr; end
        default: ;
      endcase
      checkOutput($sformatf("cycle %03h phase %0d", cur_addr, p), 3'(p), e_oe, e_out, e_cm, e_iv, e_rv);
      if (p == 4) exp_instr = {opr, opa};
      if (p == 6 && is_rdr) exp_rd = rdn;
      if (p == 7) begin
        if (is_src) exp_sa = 1'b1;
        if (leave) begin
          cur_addr = next_addr;
          dut_idle = 1'b0;
        end else begin
          dut_idle = 1'b1;
        end
      end
    end
  endtask

  // Directed scenarios first, then randomized cycles of all instruction kinds.
  initial begin
    logic [3:0] ropr, ropa;
    int kind;
    rst_n = 1'b0; run = 1'b0; fetch_addr = '0; src_value = '0; wr_data = '0; bus_in = '0;
    cur_addr = '0;
    resetModel();
    @(negedge clk);
    #1;
    checkOutput("reset", 3'd7, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("reset bus_out", 12'(bus_out), 12'h0);
    rst_n = 1'b1;

    runCycle(12'h3A5, 4'h0, 4'h0, 8'h00, 4'h0, 4'h0, 1'b0, 12'h000, -1);
    runCycle(12'h1F0, 4'h2, 4'h5, 8'hC7, 4'h0, 4'h0, 1'b1, 12'h6B2, -1);
    runCycle(12'h000, 4'hE, 4'h2, 8'h00, 4'h9, 4'h0, 1'b0, 12'h000, -1);
    runCycle(12'h804, 4'hE, 4'hA, 8'h00, 4'h0, 4'h6, 1'b0, 12'h000, -1);
    for (int i = 0; i < 5; i++) idleStep(1'b0, 12'($urandom));
    runCycle(12'h5C3, 4'h2, 4'h4, 8'h3D, 4'h1, 4'h0, 1'b0, 12'h000, -1);
    runCycle(12'h777, 4'hE, 4'h2, 8'h00, 4'h5, 4'h3, 1'b0, 12'h000, 6);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 3));
      ropr = 4'($urandom); ropa = 4'($urandom);
      if (kind == 0) begin ropr = 4'h2; ropa[0] = 1'b1; end
      if (kind == 1) begin ropr = 4'hE; ropa = 4'h2; end
      if (kind == 2) begin ropr = 4'hE; ropa = 4'hA; end
      if (dut_idle && ($urandom_range(0, 3) == 0)) idleStep(1'b0, 12'($urandom));
      runCycle(12'($urandom), ropr, ropa, 8'($urandom), 4'($urandom), 4'($urandom),
               1'($urandom), 12'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
